io_copy_master: RTL and testbench

Bus-initiator block driving the IO-space request interface (`address_io`/`data_in_io`/`control_io` → `data_out_io`) from the master side. Performs DMA-style block copies and constant fills over IO-mapped devices, such as clearing or scrolling VGA VRAM or moving SD-controller buffers, without CPU involvement. It sits in front of `memory_io`, muxed with the CPU's request port. It honours the IO port's fixed 2-cycle read-return latency and single-cycle write strobes.

---
 rtl/io_copy_master.sv | 121 ++++++++++++
 tb/tb_io_copy_master.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/io_copy_master.sv
//==============================================================================
// Module   : io_copy_master
// Purpose  : IO-space bus initiator for block copies and constant fills.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module io_copy_master #(
    parameter int COUNT_W = 16
) (
    input  logic               main_clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [31:0]        cmd_src_addr,
    input  logic [31:0]        cmd_dst_addr,
    input  logic [COUNT_W-1:0] cmd_count,
    input  logic               cmd_byte,
    input  logic               cmd_fill,
    input  logic [15:0]        cmd_fill_data,
    input  logic               io_stall,
    output logic [31:0]        address_io,
    output logic [15:0]        data_in_io,
    output logic [1:0]         control_io,
    input  logic [15:0]        data_out_io,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_W1   = 3'd2,
        S_CAP  = 3'd3,
        S_WR   = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    state_t             r_state;
    logic [31:0]        r_src;
    logic [31:0]        r_dst;
    logic [COUNT_W-1:0] r_remaining;
    logic               r_byte;
    logic               r_fill;
    logic [15:0]        r_fill_data;
    logic [15:0]        r_data;

    logic [31:0]        w_stride;
    logic               w_accept;
    logic               w_rd_issue;
    logic               w_wr_issue;

    assign w_stride   = r_byte ? 32'd1 : 32'd2;
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_rd_issue = (r_state == S_RD) && !io_stall;
    assign w_wr_issue = (r_state == S_WR) && !io_stall;

    always_ff @(posedge main_clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_src       <= 32'd0;
            r_dst       <= 32'd0;
            r_remaining <= '0;
            r_byte      <= 1'b0;
            r_fill      <= 1'b0;
            r_fill_data <= 16'd0;
            r_data      <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_src       <= cmd_src_addr;
                        r_dst       <= cmd_dst_addr;
                        r_remaining <= cmd_count;
                        r_byte      <= cmd_byte;
                        r_fill      <= cmd_fill;
                        r_fill_data <= cmd_fill_data;
                        if (cmd_count == '0)
                            r_state <= S_FIN;
                        else
                            r_state <= cmd_fill ? S_WR : S_RD;
                    end
                end
                S_RD: begin
                    if (!io_stall)
                        r_state <= S_W1;
                end
                S_W1: r_state <= S_CAP;
                // The read is already in flight, so capture happens regardless of stall.
                S_CAP: begin
                    r_data  <= data_out_io;
                    r_state <= S_WR;
                end
                S_WR: begin
                    if (!io_stall) begin
                        r_dst       <= r_dst + w_stride;
                        r_src       <= r_src + w_stride;
                        r_remaining <= r_remaining - COUNT_W'(1);
                        if (r_remaining == COUNT_W'(1))
                            r_state <= S_FIN;
                        else
                            r_state <= r_fill ? S_WR : S_RD;
                    end
                end
                S_FIN:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Issue strobes depend on the live stall input so a released stall issues in the same cycle.
    assign address_io = w_rd_issue ? r_src : (w_wr_issue ? r_dst : 32'd0);
    assign data_in_io = w_wr_issue ? (r_fill ? r_fill_data : r_data) : 16'd0;
    assign control_io = w_rd_issue ? {1'b0, r_byte} : (w_wr_issue ? {1'b1, r_byte} : 2'b00);
    assign busy       = (r_state != S_IDLE) && (r_state != S_FIN);
    assign done       = (r_state == S_FIN);
    assign cmd_ready  = (r_state == S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_io_copy_master.sv
//==============================================================================
// Module   : tb_io_copy_master
// Purpose  : Directed scoreboard bench for io_copy_master.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_io_copy_master;

    logic        main_clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_src_addr;
    logic [31:0] cmd_dst_addr;
    logic [15:0] cmd_count;
    logic        cmd_byte;
    logic        cmd_fill;
    logic [15:0] cmd_fill_data;
    logic        io_stall;
    logic [31:0] address_io;
    logic [15:0] data_in_io;
    logic [1:0]  control_io;
    logic [15:0] data_out_io;
    logic        busy;
    logic        done;

    io_copy_master #(.COUNT_W(16)) dut (
        .main_clk      (main_clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_src_addr  (cmd_src_addr),
        .cmd_dst_addr  (cmd_dst_addr),
        .cmd_count     (cmd_count),
        .cmd_byte      (cmd_byte),
        .cmd_fill      (cmd_fill),
        .cmd_fill_data (cmd_fill_data),
        .io_stall      (io_stall),
        .address_io    (address_io),
        .data_in_io    (data_in_io),
        .control_io    (control_io),
        .data_out_io   (data_out_io),
        .busy          (busy),
        .done          (done)
    );

    always #5 main_clk = ~main_clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge main_clk) cyc <= cyc + 1;

    // Bus model: read data returns two cycles after the address was presented.
    logic [31:0] r_p1 = 32'd0;
    logic [31:0] r_p2 = 32'd0;

    function automatic logic [15:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h8080_0000: return 16'h1111;
            32'h8080_0002: return 16'h2222;
            32'h8080_0004: return 16'h3333;
            default:       return a[15:0] ^ 16'h5A5A;
        endcase
    endfunction

    always @(posedge main_clk) begin
        r_p1 <= address_io;
        r_p2 <= r_p1;
    end
    assign data_out_io = mem_rd(r_p2);

    typedef struct {
        logic [31:0] addr;
        logic [15:0] data;
        logic [1:0]  ctl;
        int          cyc;
    } wr_t;

    wr_t sb[$];
    wr_t mon_e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [15:0] d, input logic [1:0] c, input int t);
        wr_t e;
        e.addr = a; e.data = d; e.ctl = c; e.cyc = t;
        sb.push_back(e);
    endtask

    always @(negedge main_clk) begin
        if (control_io[1]) begin
            if (sb.size() == 0) begin
                check("unexpected_write", {30'd0, control_io}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("wr_addr", address_io, mon_e.addr);
                check("wr_ctl", {30'd0, control_io}, {30'd0, mon_e.ctl});
                check("wr_data", {16'd0, (control_io[0] ? {8'h00, data_in_io[7:0]} : data_in_io)},
                      {16'd0, mon_e.data});
                check("wr_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic issue(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                         input logic b, input logic f, input logic [15:0] fd, output int a);
        int k;
        @(posedge main_clk); #1;
        k = 0;
        while (!cmd_ready && k < 50) begin
            @(posedge main_clk); #1;
            k++;
        end
        check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
        cmd_src_addr  = s;
        cmd_dst_addr  = d;
        cmd_count     = n;
        cmd_byte      = b;
        cmd_fill      = f;
        cmd_fill_data = fd;
        cmd_valid     = 1'b1;
        a = cyc;
        @(posedge main_clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp);
        int k;
        k = 0;
        @(negedge main_clk);
        while (!done && k < 200) begin
            @(negedge main_clk);
            k++;
        end
        check({tag, "_done_cycle"}, cyc, exp);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        @(negedge main_clk);
        check({tag, "_done_cleared"}, {31'd0, done}, 32'd0);
        check({tag, "_ready_after"}, {31'd0, cmd_ready}, 32'd1);
        check({tag, "_sb_empty"}, sb.size(), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ctl"},   {30'd0, control_io}, 32'd0);
        check({tag, "_addr"},  address_io, 32'd0);
        check({tag, "_wdata"}, {16'd0, data_in_io}, 32'd0);
        check({tag, "_busy"},  {31'd0, busy}, 32'd0);
        check({tag, "_done"},  {31'd0, done}, 32'd0);
        check({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        int a;
        reset         = 1'b1;
        cmd_valid     = 1'b0;
        cmd_src_addr  = 32'd0;
        cmd_dst_addr  = 32'd0;
        cmd_count     = 16'd0;
        cmd_byte      = 1'b0;
        cmd_fill      = 1'b0;
        cmd_fill_data = 16'd0;
        io_stall      = 1'b0;
        repeat (3) @(posedge main_clk);
        @(negedge main_clk);
        check_idle_outputs("reset");
        @(posedge main_clk); #1;
        reset = 1'b0;

        // Word copy of three elements, one write every four cycles.
        issue(32'h8080_0000, 32'h8080_0100, 16'd3, 1'b0, 1'b0, 16'h0000, a);
        push_wr(32'h8080_0100, 16'h1111, 2'b10, a + 4);
        push_wr(32'h8080_0102, 16'h2222, 2'b10, a + 8);
        push_wr(32'h8080_0104, 16'h3333, 2'b10, a + 12);
        wait_done("copy", a + 13);

        // Byte fill: back-to-back writes.
        issue(32'h0, 32'h8080_0010, 16'd4, 1'b1, 1'b1, 16'h00AB, a);
        for (int i = 0; i < 4; i++)
            push_wr(32'h8080_0010 + 32'(i), 16'h00AB, 2'b11, a + 1 + i);
        wait_done("fill", a + 5);

        // Zero count completes immediately with no bus activity.
        issue(32'h8080_0000, 32'h8080_0400, 16'd0, 1'b0, 1'b0, 16'h0000, a);
        wait_done("zero", a + 1);

        // Stall the first element's write for five cycles.
        issue(32'h8080_0000, 32'h8080_0200, 16'd2, 1'b0, 1'b0, 16'h0000, a);
        push_wr(32'h8080_0200, 16'h1111, 2'b10, a + 9);
        push_wr(32'h8080_0202, 16'h2222, 2'b10, a + 13);
        repeat (3) begin @(posedge main_clk); #1; end
        io_stall = 1'b1;
        repeat (5) begin @(posedge main_clk); #1; end
        io_stall = 1'b0;
        wait_done("stall", a + 14);

        // Reset during W1 of the second of four elements.
        issue(32'h8080_0000, 32'h8080_0300, 16'd4, 1'b0, 1'b0, 16'h0000, a);
        push_wr(32'h8080_0300, 16'h1111, 2'b10, a + 4);
        repeat (5) begin @(posedge main_clk); #1; end
        check("rst_cycle", cyc, a + 6);
        reset = 1'b1;
        @(posedge main_clk); #1;
        reset = 1'b0;
        @(negedge main_clk);
        check_idle_outputs("midreset");
        repeat (12) @(negedge main_clk);
        check("midreset_sb_empty", sb.size(), 32'd0);

        // Word fill wrapping past the top of the address space.
        issue(32'h0, 32'hFFFF_FFFE, 16'd2, 1'b0, 1'b1, 16'hBEEF, a);
        push_wr(32'hFFFF_FFFE, 16'hBEEF, 2'b10, a + 1);
        push_wr(32'h0000_0000, 16'hBEEF, 2'b10, a + 2);
        wait_done("wrap", a + 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
